// File: rtl/boot_loader_pkg.sv
// Shared types and frame constants for the byte-stream boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_WAIT_MAGIC = 3'd0,
        S_LEN_HI     = 3'd1,
        S_LEN_LO     = 3'd2,
        S_PAYLOAD    = 3'd3,
        S_CHECK      = 3'd4,
        S_DONE       = 3'd5,
        S_ERROR      = 3'd6
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hB0;
    localparam int         WORD_BYTES    = 4;
    localparam int         LEN_WIDTH     = 16;

    // A frame length is usable only if it is non-zero and fits the memory.
    function automatic logic len_valid(input logic [LEN_WIDTH-1:0] n, input int aw);
        return (n != '0) && ({1'b0, n} <= (17'd1 << aw));
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_PAYLOAD) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs payload bytes MSB-first into 32-bit words and keeps the running XOR checksum.
module boot_loader_word_assembler
    import boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready,
    output logic [7:0]  o_checksum
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic [7:0]  r_chk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_chk   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_chk   <= '0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
            r_chk   <= r_chk ^ i_byte;
        end
    end

    // Word and ready are combinational so the write can be registered on the same edge as the last byte.
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));
    assign o_checksum   = r_chk;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: frames a byte stream into instruction-memory writes and releases the core once verified.
//   state        | meaning
//   S_WAIT_MAGIC | idle after reset, waiting for the frame start byte
//   S_LEN_HI     | expecting length high byte
//   S_LEN_LO     | expecting length low byte, length is validated here
//   S_PAYLOAD    | receiving 4*N payload bytes, one memory write per word
//   S_CHECK      | expecting XOR checksum of the payload
//   S_DONE       | image verified, core released
//   S_ERROR      | frame rejected, core held in reset
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_data,
    output logic                  o_cpu_rst,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int IW = ADDR_WIDTH + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_len_hi;
    logic [IW-1:0]         r_last_idx;
    logic [IW-1:0]         r_word_idx;
    logic [TW-1:0]         r_tmo_cnt;
    logic                  r_in_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_data;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_error;

    logic                  w_hs;
    logic                  w_timeout;
    logic                  w_asm_clear;
    logic                  w_asm_valid;
    logic                  w_word_ready;
    logic [31:0]           w_word;
    logic [7:0]            w_checksum;
    logic [LEN_WIDTH-1:0]  w_len;

    assign w_hs        = i_in_valid && r_in_ready;
    assign w_len       = {r_len_hi, i_in_data};
    assign w_asm_clear = w_hs && (r_state == S_LEN_LO);
    assign w_asm_valid = w_hs && (r_state == S_PAYLOAD);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && is_timed(r_state) && !w_hs && (r_tmo_cnt == '0);

    boot_loader_word_assembler u_word_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_asm_valid),
        .i_byte       (i_in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready),
        .o_checksum   (w_checksum)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_ERROR;
        end else if (w_hs) begin
            case (r_state)
                S_WAIT_MAGIC, S_DONE, S_ERROR: begin
                    if (i_in_data == MAGIC) w_state_nxt = S_LEN_HI;
                end
                S_LEN_HI:  w_state_nxt = S_LEN_LO;
                S_LEN_LO:  w_state_nxt = len_valid(w_len, ADDR_WIDTH) ? S_PAYLOAD : S_ERROR;
                S_PAYLOAD: begin
                    if (w_word_ready && (r_word_idx == r_last_idx)) w_state_nxt = S_CHECK;
                end
                S_CHECK:   w_state_nxt = (i_in_data == w_checksum) ? S_DONE : S_ERROR;
                default:   w_state_nxt = S_WAIT_MAGIC;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_WAIT_MAGIC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len_hi   <= '0;
            r_last_idx <= '0;
            r_word_idx <= '0;
        end else begin
            if (w_hs && (r_state == S_LEN_HI)) r_len_hi <= i_in_data;
            // Index is one bit wider than the address so a full-memory image never wraps.
            if (w_asm_clear) begin
                r_last_idx <= IW'(w_len - 16'd1);
                r_word_idx <= '0;
            end else if (w_word_ready) begin
                r_word_idx <= r_word_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_hs || !is_timed(r_state)) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_ready  <= 1'b0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            r_imem_we  <= w_word_ready;
            if (w_word_ready) begin
                r_imem_addr <= r_word_idx[ADDR_WIDTH-1:0];
                r_imem_data <= w_word;
            end
            r_cpu_rst <= (w_state_nxt != S_DONE);
            r_done    <= (w_state_nxt == S_DONE);
            r_error   <= (w_state_nxt == S_ERROR);
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_imem_we   = r_imem_we;
    assign o_imem_addr = r_imem_addr;
    assign o_imem_data = r_imem_data;
    assign o_cpu_rst   = r_cpu_rst;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framing, checksum, length limits, timeout, full image, async reset.
module tb_boot_loader;

    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          cpu_rst;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];

    always #5 clk = ~clk;

    boot_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hB0), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_data (imem_data),
        .o_cpu_rst   (cpu_rst),
        .o_done      (done),
        .o_error     (error)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            n_fail++;
            $display("FAIL send_byte_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, imem_we, imem_addr, imem_data, cpu_rst, done, error} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b required 0 0 00 0 1 0 0",
                     in_ready, imem_we, imem_addr, imem_data, cpu_rst, done, error);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b required 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_first_edge: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] f0[7] = '{8'hB0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20};
        logic [7:0] f1[4] = '{8'h8C, 8'h01, 8'h00, 8'h04};
        wr_addr.delete();
        wr_data.delete();
        foreach (f0[i]) send_byte(f0[i]);
        @(negedge clk);
        n_checks++;
        if ({imem_we, imem_addr, imem_data} !== {1'b1, 8'h00, 32'h00000020}) begin
            n_fail++;
            $display("FAIL basic_word0: we=%b addr=%h data=%h required 1 00 00000020", imem_we, imem_addr, imem_data);
        end
        foreach (f1[i]) send_byte(f1[i]);
        @(negedge clk);
        n_checks++;
        if ({imem_we, imem_addr, imem_data} !== {1'b1, 8'h01, 32'h8C010004}) begin
            n_fail++;
            $display("FAIL basic_word1: we=%b addr=%h data=%h required 1 01 8C010004", imem_we, imem_addr, imem_data);
        end
        n_checks++;
        if ({done, cpu_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_before_chk: done=%b cpu_rst=%b required 0 1", done, cpu_rst);
        end
        send_byte(8'hA9);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_rst, error} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_done: done=%b cpu_rst=%b err=%b required 1 0 0", done, cpu_rst, error);
        end
        n_checks++;
        if (wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d required 2", wr_addr.size());
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] f[12] = '{8'hB0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20,
                              8'h8C, 8'h01, 8'h00, 8'h04, 8'h00};
        wr_addr.delete();
        wr_data.delete();
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_checks++;
        if ({error, done, cpu_rst} !== 3'b101) begin
            n_fail++;
            $display("FAIL badchk_flags: err=%b done=%b cpu_rst=%b required 1 0 1", error, done, cpu_rst);
        end
        n_checks++;
        if (wr_addr.size() !== 2 || wr_data[0] !== 32'h00000020 || wr_data[1] !== 32'h8C010004) begin
            n_fail++;
            $display("FAIL badchk_writes: count=%0d required 2 words 00000020 8C010004", wr_addr.size());
        end
    endtask

    task automatic test_bad_length();
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'hB0);
        @(negedge clk);
        n_checks++;
        if ({error, cpu_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL len_magic_clears_error: err=%b cpu_rst=%b required 0 1", error, cpu_rst);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        n_checks++;
        if ({error, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL len_zero: err=%b done=%b required 1 0", error, done);
        end
        send_byte(8'hB0);
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL len_257: err=%b required 1", error);
        end
        n_checks++;
        if (wr_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL len_no_writes: count=%0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] f[5]  = '{8'hB0, 8'h00, 8'h01, 8'h12, 8'h34};
        logic [7:0] g[12] = '{8'hB0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20,
                              8'h8C, 8'h01, 8'h00, 8'h04, 8'hA9};
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        repeat (15) @(negedge clk);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: err=%b after 15 idle cycles required 0", error);
        end
        @(negedge clk);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire: err=%b after 16 idle cycles required 1", error);
        end
        wr_addr.delete();
        wr_data.delete();
        foreach (g[i]) send_byte(g[i]);
        @(negedge clk);
        n_checks++;
        if ({error, done, cpu_rst} !== 3'b010) begin
            n_fail++;
            $display("FAIL timeout_recover: err=%b done=%b cpu_rst=%b required 0 1 0", error, done, cpu_rst);
        end
    endtask

    task automatic test_full_image();
        logic [7:0]  chk;
        logic [31:0] w;
        int          bad;
        apply_reset();
        send_byte(8'h12);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(8'h55);
        send_byte(8'hB0);
        send_byte(8'h01);
        send_byte(8'h00);
        chk = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, ~8'(i)};
            for (int k = 3; k >= 0; k--) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(w[k*8 +: 8]);
                chk = chk ^ w[k*8 +: 8];
            end
        end
        send_byte(chk);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_rst, error} !== 3'b100) begin
            n_fail++;
            $display("FAIL full_done: done=%b cpu_rst=%b err=%b required 1 0 0", done, cpu_rst, error);
        end
        n_checks++;
        if (wr_addr.size() !== 256) begin
            n_fail++;
            $display("FAIL full_count: got %0d required 256", wr_addr.size());
        end
        bad = 0;
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            w = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, ~8'(i)};
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== w) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL full_contents: %0d words wrong required 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] p[9]  = '{8'hB0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h8C, 8'h01};
        logic [7:0] g[12] = '{8'hB0, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20,
                              8'h8C, 8'h01, 8'h00, 8'h04, 8'hA9};
        logic [7:0] r[6]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        apply_reset();
        foreach (p[i]) send_byte(p[i]);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, imem_we, imem_addr, imem_data, cpu_rst, done, error} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b required 0 0 00 0 1 0 0",
                     in_ready, imem_we, imem_addr, imem_data, cpu_rst, done, error);
        end
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        foreach (g[i]) send_byte(g[i]);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_rst} !== 2'b10 || wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL post_reset_load: done=%b cpu_rst=%b writes=%0d required 1 0 2", done, cpu_rst, wr_addr.size());
        end
        send_byte(8'hB0);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL reload_holds: done=%b cpu_rst=%b required 0 1", done, cpu_rst);
        end
        foreach (r[i]) send_byte(r[i]);
        @(negedge clk);
        n_checks++;
        if (cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_before_chk: cpu_rst=%b required 1", cpu_rst);
        end
        send_byte(8'h22);
        @(negedge clk);
        n_checks++;
        if ({done, cpu_rst} !== 2'b10 || wr_data[wr_data.size()-1] !== 32'hDEADBEEF || wr_addr[wr_addr.size()-1] !== 8'h00) begin
            n_fail++;
            $display("FAIL reload_done: done=%b cpu_rst=%b last=%h required 1 0 DEADBEEF@00",
                     done, cpu_rst, wr_data[wr_data.size()-1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_full_image();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
